tipi_read_mux: RTL and testbench
================================

# tipi_read_mux

Parametrised, registered read-data multiplexer for the TIPI register file. It selects one of N W-bit sources by a priority-encoded select vector when a read strobe rises, then holds the captured word and its source index stable for the whole strobe. It also reports misses and multi-select decode errors, and keeps saturating read/miss counters for debug. It sits between the TIPI address decode and the CPU data-bus return path, replacing combinational per-register muxing.

## Interface
Parameters:
- N, default 4: number of source channels, legal range 2..16.
- W, default 8: data width per channel.
- MISS_VAL, default {W{1'b0}}: word returned when no select is active.
- CW, default 16: width of the debug counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sel  in  N  channel selects; bit 0 has the highest priority.
- din  in  N*W  channel data; channel i occupies din[i*W +: W].
- rd_req  in  1  read strobe, level, synchronous to clk.
- clr  in  1  synchronous clear of multi_err and both counters.
- dout  out  W  captured read word.
- dout_valid  out  1  dout and dout_idx are stable and valid.
- dout_idx  out  max(1,$clog2(N))  index of the captured channel; 0 on a miss.
- hit  out  1  the last capture found at least one active select.
- multi_err  out  1  sticky; set when a capture sees more than one select active.
- rd_count  out  CW  saturating count of captures.
- miss_count  out  CW  saturating count of captures with no active select.

## Operation
- State machine: IDLE and HOLD.
- IDLE to HOLD: on a cycle where rd_req=1 and the registered copy of rd_req is 0 (a rising edge).
- On that transition the block:
  - loads dout from the lowest-index set bit of sel, or MISS_VAL if sel is all zero;
  - loads dout_idx with that index, or 0 on a miss;
  - sets hit to (sel != 0);
  - sets dout_valid to 1.
- HOLD: dout, dout_idx and hit are frozen. Changes on sel or din are ignored.
- HOLD to IDLE: in the first cycle with rd_req=0. dout_valid drops to 0. dout, dout_idx and hit keep their last values.
- In IDLE, rd_req held high with no rising edge does not capture.
- Capture side effects:
  - rd_count increments and saturates at all ones.
  - miss_count increments on a miss and saturates at all ones.
  - multi_err is set if popcount(sel) > 1.
- clr has priority over increment and set in the same cycle: the counters become 0 and multi_err becomes 0, and that cycle's capture does not count. The data capture itself still happens normally.
- Reset values: state IDLE, dout=MISS_VAL, dout_idx=0, dout_valid=0, hit=0, multi_err=0, rd_count=0, miss_count=0, registered rd_req=0.
- Reset asserted mid-HOLD returns the block to IDLE at once.
  - If rd_req is still high after reset releases, it is not treated as an edge. It must go low and then high again to capture.

## Timing
- Latency: if rd_req is first sampled high at edge k, dout and dout_valid are updated at edge k (visible in cycle k+1).
- dout_valid falls at the first edge that samples rd_req=0.
- Minimum rd_req low time between captures: 1 cycle. Back-to-back pulses (1 high, 1 low, 1 high) each capture.
- sel and din must be stable at the capture edge only.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single-channel read, N=4, W=8, din channels = {0x44,0x33,0x22,0x11}, sel=4'b0100, rd_req raised for 3 cycles. Required: dout=0x33, dout_idx=2, hit=1, dout_valid=1 one cycle after the rise and for the remainder of the strobe, then 0. rd_count=1.
- Priority and error: sel=4'b1010. Required: dout from channel 1, dout_idx=1, multi_err=1 and still 1 after three more clean reads. Then pulse clr: multi_err=0, rd_count=0.
- Miss: sel=0, MISS_VAL=0xFF. Required: dout=0xFF, hit=0, dout_idx=0, miss_count=1.
- Hold stability: change sel and din every cycle while rd_req is high. Required: dout and dout_idx never change until rd_req falls. Back-to-back 1-high/1-low pulses give one capture each.
- Reset mid-HOLD: assert reset with rd_req high, release with rd_req still high. Required: all outputs at reset values, and no capture until rd_req goes 0 and then 1.
- Saturation: CW=4, 20 misses. Required: rd_count=15, miss_count=15, no wrap.

Source files
------------

// File: rtl/tipi_read_mux.sv
// tipi_read_mux
// Registered read-data multiplexer for the TIPI register file. A rising edge
// on rd_req captures the highest-priority selected channel (bit 0 wins). The
// captured word and its index are then held stable until the strobe drops.
// Misses, multi-select decode errors and saturating debug counters are also
// tracked here.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   sel        N channel selects, bit 0 highest priority
//   din        N*W channel data, channel i at din[i*W +: W]
//   rd_req     read strobe (level)
//   clr        synchronous clear of multi_err and both counters
//   dout       captured read word (MISS_VAL on a miss)
//   dout_valid high while the captured word is held
//   dout_idx   index of the captured channel, 0 on a miss
//   hit        last capture had at least one active select
//   multi_err  sticky: a capture saw more than one select active
//   rd_count   saturating count of captures
//   miss_count saturating count of captures with no select active
module tipi_read_mux #(
  parameter int             N        = 4,
  parameter int             W        = 8,
  parameter logic [W-1:0]   MISS_VAL = {W{1'b0}},
  parameter int             CW       = 16,
  localparam int            IW       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    sel,
  input  logic [N*W-1:0]  din,
  input  logic            rd_req,
  input  logic            clr,
  output logic [W-1:0]    dout,
  output logic            dout_valid,
  output logic [IW-1:0]   dout_idx,
  output logic            hit,
  output logic            multi_err,
  output logic [CW-1:0]   rd_count,
  output logic [CW-1:0]   miss_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_next;

  logic rd_q;    // rd_req from the previous cycle
  logic armed;   // rd_req has been seen low since reset
  logic capture;

  logic [W-1:0]  pick_data;
  logic [IW-1:0] pick_idx;
  logic          any_sel;
  logic          multi_sel;
  logic [N-1:0]  sel_m1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rd_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      rd_q  <= rd_req;
      if (!rd_req) armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and capture strobe
  // ---------------------------------------------------------------------------
  // The armed bit stops a strobe that was already high across reset release
  // from looking like a fresh edge (rd_q resets to 0).
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a variable
    // unassigned, which would infer a latch.
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && !rd_q && armed) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!rd_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Priority select: scan from the top so the lowest set bit wins last
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_data = MISS_VAL;
    pick_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        pick_data = din[i*W +: W];
        pick_idx  = IW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign sel_m1    = sel - {{(N-1){1'b0}}, 1'b1};
  assign any_sel   = |sel;
  assign multi_sel = |(sel & sel_m1);

  // ---------------------------------------------------------------------------
  // Captured data; held through HOLD and after the strobe drops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= MISS_VAL;
      dout_idx <= '0;
      hit      <= 1'b0;
    end else if (capture) begin
      dout     <= pick_data;
      dout_idx <= pick_idx;
      hit      <= any_sel;
    end
  end

  assign dout_valid = (state == HOLD);

  // ---------------------------------------------------------------------------
  // Debug counters and sticky error; clr beats a same-cycle capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count   <= '0;
      miss_count <= '0;
      multi_err  <= 1'b0;
    end else if (clr) begin
      rd_count   <= '0;
      miss_count <= '0;
      multi_err  <= 1'b0;
    end else if (capture) begin
      if (rd_count != {CW{1'b1}})
        rd_count <= rd_count + CW'(1);
      if (!any_sel && (miss_count != {CW{1'b1}}))
        miss_count <= miss_count + CW'(1);
      if (multi_sel)
        multi_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tipi_read_mux.sv
// Directed bench for tipi_read_mux (N=4, W=8, MISS_VAL=0xFF, CW=4).
// Expected captures are pushed onto a scoreboard queue when a read is
// launched and popped when the DUT presents dout_valid.
module tb_tipi_read_mux;

  localparam int             N    = 4;
  localparam int             W    = 8;
  localparam int             CW   = 4;
  localparam int             IW   = 2;
  localparam logic [W-1:0]   MISS = 8'hFF;
  localparam logic [CW-1:0]  CMAX = '1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    sel;
  logic [N*W-1:0]  din;
  logic            rd_req;
  logic            clr;
  logic [W-1:0]    dout;
  logic            dout_valid;
  logic [IW-1:0]   dout_idx;
  logic            hit;
  logic            multi_err;
  logic [CW-1:0]   rd_count;
  logic [CW-1:0]   miss_count;

  tipi_read_mux #(.N(N), .W(W), .MISS_VAL(MISS), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .din        (din),
    .rd_req     (rd_req),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_idx   (dout_idx),
    .hit        (hit),
    .multi_err  (multi_err),
    .rd_count   (rd_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          hit;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference counters and sticky error
  logic [CW-1:0] m_rd;
  logic [CW-1:0] m_miss;
  logic          m_multi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] s, input logic [N*W-1:0] d);
    exp_t e;
    e.data = MISS;
    e.idx  = '0;
    e.hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s[i] && !e.hit) begin
        e.data = d[i*W +: W];
        e.idx  = IW'(i);
        e.hit  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".dout"},   32'(dout),       32'(MISS));
    check({tag, ".idx"},    32'(dout_idx),   0);
    check({tag, ".valid"},  32'(dout_valid), 0);
    check({tag, ".hit"},    32'(hit),        0);
    check({tag, ".multi"},  32'(multi_err),  0);
    check({tag, ".rd"},     32'(rd_count),   0);
    check({tag, ".miss"},   32'(miss_count), 0);
  endtask

  // Launch one read from IDLE (rd_req low for the previous cycle), hold it
  // for 'high' cycles while scrambling sel/din, then drop it for one cycle.
  task automatic do_read(input string tag, input logic [N-1:0] s,
                         input logic [N*W-1:0] d, input int high, input logic with_clr);
    exp_t got;
    sel    = s;
    din    = d;
    rd_req = 1'b1;
    clr    = with_clr;
    sb.push_back(model(s, d));
    if (with_clr) begin
      m_rd    = '0;
      m_miss  = '0;
      m_multi = 1'b0;
    end else begin
      if (m_rd != CMAX) m_rd++;
      if ((s == '0) && (m_miss != CMAX)) m_miss++;
      if ($countones(s) > 1) m_multi = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0;
    check({tag, ".valid"}, 32'(dout_valid), 1);
    got = sb.pop_front();
    check({tag, ".dout"},  32'(dout),       32'(got.data));
    check({tag, ".idx"},   32'(dout_idx),   32'(got.idx));
    check({tag, ".hit"},   32'(hit),        32'(got.hit));
    check({tag, ".multi"}, 32'(multi_err),  32'(m_multi));
    check({tag, ".rd"},    32'(rd_count),   32'(m_rd));
    check({tag, ".miss"},  32'(miss_count), 32'(m_miss));
    for (int i = 1; i < high; i++) begin
      sel = N'($urandom);
      din = (N*W)'($urandom);
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(dout_valid), 1);
      check({tag, ".hold_dout"},  32'(dout),       32'(got.data));
      check({tag, ".hold_idx"},   32'(dout_idx),   32'(got.idx));
    end
    rd_req = 1'b0;
    sel    = N'($urandom);
    din    = (N*W)'($urandom);
    @(negedge clk);
    check({tag, ".fall_valid"}, 32'(dout_valid), 0);
    check({tag, ".fall_dout"},  32'(dout),       32'(got.data));
    check({tag, ".fall_idx"},   32'(dout_idx),   32'(got.idx));
    check({tag, ".fall_hit"},   32'(hit),        32'(got.hit));
  endtask

  logic [N*W-1:0] base_din;

  initial begin
    reset   = 1'b1;
    rd_req  = 1'b0;
    clr     = 1'b0;
    sel     = '0;
    din     = '0;
    m_rd    = '0;
    m_miss  = '0;
    m_multi = 1'b0;
    base_din = {8'h44, 8'h33, 8'h22, 8'h11};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single channel: channel 2 = 0x33
    do_read("single", 4'b0100, base_din, 3, 1'b0);

    // Priority: channel 1 wins over channel 3, multi-select sets the error
    do_read("prio", 4'b1010, base_din, 2, 1'b0);
    for (int i = 0; i < 3; i++) do_read("clean", 4'b0001, base_din, 1, 1'b0);

    // Standalone clr pulse
    clr = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    m_rd    = '0;
    m_miss  = '0;
    m_multi = 1'b0;
    check("clr.multi", 32'(multi_err),  0);
    check("clr.rd",    32'(rd_count),   0);
    check("clr.miss",  32'(miss_count), 0);

    // Miss returns MISS_VAL
    do_read("miss", 4'b0000, base_din, 2, 1'b0);

    // Hold stability on a long strobe, then back-to-back 1-high/1-low pulses
    for (int i = 0; i < 4; i++)
      do_read("b2b", N'($urandom), (N*W)'($urandom), (i == 0) ? 5 : 1, 1'b0);

    // clr coinciding with a capture: data captured, counters cleared
    do_read("clrcap", 4'b0011, base_din, 1, 1'b1);

    // Reset asserted mid-HOLD, released with rd_req still high
    sel    = 4'b1000;
    din    = base_din;
    rd_req = 1'b1;
    @(negedge clk);
    check("rst_hold.valid", 32'(dout_valid), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_async");
    m_rd    = '0;
    m_miss  = '0;
    m_multi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_high.valid", 32'(dout_valid), 0);
      check("rst_high.rd",    32'(rd_count),   0);
    end
    rd_req = 1'b0;
    @(negedge clk);
    check("rst_low.valid", 32'(dout_valid), 0);
    do_read("post_rst", 4'b1000, base_din, 1, 1'b0);

    // Saturation: 20 misses on 4-bit counters
    for (int i = 0; i < 20; i++) do_read("sat", 4'b0000, base_din, 1, 1'b0);
    check("sat.rd_final",   32'(rd_count),   15);
    check("sat.miss_final", 32'(miss_count), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
